// File: rtl/sum_bcd_display.sv
// rtl/sum_bcd_display.sv - serial binary-to-BCD converter driving three 7-segment displays
//
// Purpose: captures a WIDTH-bit binary sum on a sum_valid pulse and converts it
// to DIGITS BCD digits using shift-and-add-3, one bit per clock. The registered
// result is decoded to active-low 7-segment patterns for HEX2..HEX0.
//
// Ports:
//   clock      in   1         system clock, all state updates on posedge
//   reset      in   1         synchronous, active-high reset
//   sum        in   WIDTH     binary value to convert
//   sum_valid  in   1         one-cycle start pulse, accepted only when idle
//   busy       out  1         high while a conversion is in progress
//   done       out  1         one-cycle pulse when bcd is updated
//   bcd        out  4*DIGITS  {hundreds, tens, ones}, registered
//   HEX0       out  7         ones digit, active-low segments {g..a}
//   HEX1       out  7         tens digit, active-low segments {g..a}
//   HEX2       out  7         hundreds digit, active-low segments {g..a}
module sum_bcd_display #(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      sum,
  input  logic                  sum_valid,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            HEX0,
  output logic [6:0]            HEX1,
  output logic [6:0]            HEX2
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    CONVERT
  } state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] bin, bin_next;
  logic [BW-1:0]    scratch, scratch_next;
  logic [CW-1:0]    count, count_next;
  logic [BW-1:0]    bcd_next;
  logic             busy_next, done_next;

  logic [BW-1:0]    adjusted;
  logic [BW-1:0]    shifted;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      bin     <= '0;
      scratch <= '0;
      count   <= '0;
      bcd     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      bin     <= bin_next;
      scratch <= scratch_next;
      count   <= count_next;
      bcd     <= bcd_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  always_comb begin
    state_next   = state;
    bin_next     = bin;
    scratch_next = scratch;
    count_next   = count;
    bcd_next     = bcd;
    busy_next    = busy;
    done_next    = 1'b0;

    // Add 3 to every digit >= 5 so the following shift carries correctly
    // into the next decimal digit. A digit is at most 9 here, so +3 stays
    // within 4 bits.
    adjusted = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        adjusted[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
    shifted = {adjusted[BW-2:0], bin[WIDTH-1]};

    case (state)
      IDLE: begin
        if (sum_valid) begin
          bin_next     = sum;
          scratch_next = '0;
          count_next   = '0;
          busy_next    = 1'b1;
          state_next   = CONVERT;
        end
      end
      CONVERT: begin
        scratch_next = shifted;
        bin_next     = {bin[WIDTH-2:0], 1'b0};
        count_next   = count + 1'b1;
        if (count == CW'(WIDTH - 1)) begin
          // Last bit: publish the completed digits in one step so bcd
          // never exposes an intermediate value.
          bcd_next   = shifted;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          count_next = '0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign HEX0 = seg7(bcd[3:0]);
  assign HEX1 = seg7(bcd[7:4]);
  assign HEX2 = seg7(bcd[11:8]);

endmodule

// File: tb/tb_sum_bcd_display.sv
// tb/tb_sum_bcd_display.sv - directed self-checking bench for sum_bcd_display
module tb_sum_bcd_display;

  logic        clock = 1'b0;
  logic        reset;
  logic [8:0]  sum;
  logic        sum_valid;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic [6:0]  HEX0, HEX1, HEX2;

  int errors = 0;
  int checks = 0;

  sum_bcd_display #(.WIDTH(9), .DIGITS(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .sum       (sum),
    .sum_valid (sum_valid),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .HEX0      (HEX0),
    .HEX1      (HEX1),
    .HEX2      (HEX2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present sum for one sampling edge; returns at the negedge after that edge.
  task automatic pulse(input logic [8:0] value);
    @(negedge clock);
    sum       = value;
    sum_valid = 1'b1;
    @(negedge clock);
    sum_valid = 1'b0;
  endtask

  // Called at the negedge right after the accepting edge. Returns at the
  // negedge where done is seen, with the edge count and busy-cycle count.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat         = 0;
    busy_cycles = busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cycles++;
    end
    if (lat == 0) check("done_timeout", 16'd0, 16'd1);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      if (done) n++;
    end
  endtask

  int lat, bc, n;

  initial begin
    reset     = 1'b1;
    sum       = '0;
    sum_valid = 1'b0;

    // 1: reset state
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_bcd",  16'(bcd),  16'h000);
    check("rst_hex0", 16'(HEX0), 16'b1000000);
    check("rst_hex1", 16'(HEX1), 16'b1000000);
    check("rst_hex2", 16'(HEX2), 16'b1000000);

    // 2: zero, latency and busy length
    pulse(9'd0);
    check("t2_busy_start", 16'(busy), 16'd1);
    wait_done(lat, bc);
    check("t2_latency", 16'(lat), 16'd9);
    check("t2_busy_cycles", 16'(bc), 16'd9);
    check("t2_bcd", 16'(bcd), 16'h000);
    check("t2_busy_at_done", 16'(busy), 16'd0);
    @(negedge clock);
    check("t2_done_width", 16'(done), 16'd0);

    // 3: maximum adder output 510
    pulse(9'd510);
    wait_done(lat, bc);
    check("t3_latency", 16'(lat), 16'd9);
    check("t3_bcd",  16'(bcd),  16'h510);
    check("t3_hex2", 16'(HEX2), 16'b0010010);
    check("t3_hex1", 16'(HEX1), 16'b1111001);
    check("t3_hex0", 16'(HEX0), 16'b1000000);

    // 4: sum_valid while busy is ignored
    pulse(9'd511);
    @(negedge clock);
    check("t4_bcd_hold", 16'(bcd), 16'h510);
    pulse(9'd100);
    wait_done(lat, bc);
    check("t4_latency", 16'(lat), 16'd6);
    check("t4_bcd", 16'(bcd), 16'h511);
    count_dones(15, n);
    check("t4_extra_done", 16'(n), 16'd0);
    check("t4_bcd_after", 16'(bcd), 16'h511);

    // 5: reset mid-conversion aborts with no done
    pulse(9'd137);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t5_busy", 16'(busy), 16'd0);
    check("t5_bcd",  16'(bcd),  16'h000);
    count_dones(15, n);
    check("t5_no_done", 16'(n), 16'd0);
    pulse(9'd42);
    wait_done(lat, bc);
    check("t5_bcd_42", 16'(bcd), 16'h042);
    check("t5_hex1", 16'(HEX1), 16'b0011001);
    check("t5_hex0", 16'(HEX0), 16'b0100100);

    // 6: back-to-back, new request in the done cycle
    pulse(9'd99);
    wait_done(lat, bc);
    check("t6_bcd_99", 16'(bcd), 16'h099);
    check("t6_hex0", 16'(HEX0), 16'b0010000);
    sum       = 9'd100;
    sum_valid = 1'b1;
    @(negedge clock);
    sum_valid = 1'b0;
    check("t6_busy_restart", 16'(busy), 16'd1);
    wait_done(lat, bc);
    check("t6_latency", 16'(lat), 16'd9);
    check("t6_bcd_100", 16'(bcd), 16'h100);
    check("t6_hex2", 16'(HEX2), 16'b1111001);
    check("t6_hex1", 16'(HEX1), 16'b1000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
